// File: rtl/mem_access_pkg.sv
// Shared definitions for the 24-bit to byte-wide memory access controller:
// state encoding, word geometry and big-endian byte selection.
package mem_access_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_B0   = 3'd1,
    ST_B1   = 3'd2,
    ST_B2   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam int BYTES_PER_WORD = 3;

  // Byte 0 is the most-significant byte of the word.
  function automatic logic [7:0] byte_sel(input logic [23:0] word, input logic [1:0] k);
    case (k)
      2'd0:    return word[23:16];
      2'd1:    return word[15:8];
      default: return word[7:0];
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/response bundle of the memory access controller.
// master = execute-stage initiator, slave = mem_access_ctrl.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 24
);
  logic              ReqValid;
  logic              ReqWrite;
  logic [ADDR_W-1:0] ReqAddr;
  logic [DATA_W-1:0] ReqWriteData;
  logic              ReqReady;
  logic              RespValid;
  logic [DATA_W-1:0] RespReadData;
  logic              RespErr;

  modport master (
    output ReqValid, ReqWrite, ReqAddr, ReqWriteData,
    input  ReqReady, RespValid, RespReadData, RespErr
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqAddr, ReqWriteData,
    output ReqReady, RespValid, RespReadData, RespErr
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Sequences one 24-bit load/store into three big-endian byte accesses.
// Optional bounds check: define MEM_ACCESS_ADDR_CHECK_EN.
//   state   | meaning
//   IDLE    | ready for a request
//   B0..B2  | byte access k in flight on the memory port
//   DONE    | one-cycle response strobe
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 24,
  parameter int MEM_DEPTH = 64
) (
  input  logic              Clock,
  input  logic              Reset,
  mem_access_ctrl_if.slave  bus,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [7:0]        MemWriteData,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [7:0]        MemReadData
);

`ifdef MEM_ACCESS_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif
  localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'(MEM_DEPTH - BYTES_PER_WORD);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic [15:0]       shadow_q;
  logic [DATA_W-1:0] rdata_q;

  logic              accept, addr_oob;
  logic [ADDR_W-1:0] base_addr, mem_addr_nxt;
  logic              base_write;
  logic [DATA_W-1:0] base_wdata;
  logic [7:0]        mem_wdata_nxt;
  logic              mem_we_nxt, mem_re_nxt, strobe_nxt;
  logic [1:0]        k_nxt;

  assign accept   = bus.ReqValid && (state == ST_IDLE);
  assign addr_oob = ADDR_CHECK && (bus.ReqAddr > LAST_BASE);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = addr_oob ? ST_DONE : ST_B0;
      ST_B0:   state_nxt = ST_B1;
      ST_B1:   state_nxt = ST_B2;
      ST_B2:   state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Memory strobes are registered, so they are computed from the state being entered;
  // on the accept edge the latches are not yet loaded and the request is used directly.
  always_comb begin
    base_addr  = (state == ST_IDLE) ? bus.ReqAddr      : addr_q;
    base_write = (state == ST_IDLE) ? bus.ReqWrite     : write_q;
    base_wdata = (state == ST_IDLE) ? bus.ReqWriteData : wdata_q;
    k_nxt      = 2'd0;
    strobe_nxt = 1'b0;
    case (state_nxt)
      ST_B0:   begin k_nxt = 2'd0; strobe_nxt = 1'b1; end
      ST_B1:   begin k_nxt = 2'd1; strobe_nxt = 1'b1; end
      ST_B2:   begin k_nxt = 2'd2; strobe_nxt = 1'b1; end
      default: ;
    endcase
    mem_addr_nxt  = strobe_nxt ? base_addr + ADDR_W'(k_nxt) : '0;
    mem_we_nxt    = strobe_nxt && base_write;
    mem_re_nxt    = strobe_nxt && !base_write;
    mem_wdata_nxt = mem_we_nxt ? byte_sel(base_wdata, k_nxt) : 8'h00;
  end

  assign bus.ReqReady     = (state == ST_IDLE);
  assign bus.RespValid    = (state == ST_DONE);
  assign bus.RespErr      = (state == ST_DONE) && err_q;
  assign bus.RespReadData = rdata_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      MemAddr      <= '0;
      MemWriteData <= 8'h00;
      MemWrite     <= 1'b0;
      MemRead      <= 1'b0;
    end else begin
      MemAddr      <= mem_addr_nxt;
      MemWriteData <= mem_wdata_nxt;
      MemWrite     <= mem_we_nxt;
      MemRead      <= mem_re_nxt;
    end
  end

  // Byte 2 bypasses the shadow so the word is complete on the edge entering DONE.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      shadow_q <= 16'h0000;
      rdata_q  <= '0;
    end else begin
      if (accept) begin
        addr_q  <= bus.ReqAddr;
        write_q <= bus.ReqWrite;
        wdata_q <= bus.ReqWriteData;
        err_q   <= addr_oob;
      end
      if (!write_q) begin
        case (state)
          ST_B0:   shadow_q[15:8] <= MemReadData;
          ST_B1:   shadow_q[7:0]  <= MemReadData;
          ST_B2:   rdata_q        <= {shadow_q, MemReadData};
          default: ;
        endcase
      end
    end
  end

endmodule
